uart_tx_ctrl: RTL and testbench
===============================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set the number of clk cycles per serial bit; the legal minimum is 2.
REQ-002 Parameter FRAME_WIDTH, default 8, SHALL set the number of data bits per frame.
REQ-003 Parameter PARITY_EN, default 0, SHALL insert one parity bit after the data bits when 1.
REQ-004 Parameter PARITY_ODD, default 0, SHALL select odd parity when 1 and even parity when 0; it applies only when PARITY_EN=1.
REQ-005 Parameter STOP_BITS, default 1, SHALL set the stop-bit count; legal values are 1 and 2.
REQ-006 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-007 rst  input  1  reset: synchronous, active-high.
REQ-008 tx_data  input  FRAME_WIDTH  payload; sampled only on acceptance.
REQ-009 tx_valid  input  1  asserted when tx_data holds a frame to send.
REQ-010 tx_ready  output  1  high only in IDLE with rst low.
REQ-011 tx_out  output  1  registered serial line; idle level is 1.
REQ-012 tx_busy  output  1  high in every state except IDLE.
REQ-013 baud_tick  output  1  high during the last clk cycle of each bit period; this is the cnt_done source for the bit selector.
REQ-014 tx_done  output  1  one-cycle pulse during the last cycle of the final stop bit.

Function
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP.
REQ-016 A frame SHALL be accepted on any edge where tx_valid=1 and tx_ready=1.
  - On that edge: tx_data is latched into a shift register, the FSM moves to START, tx_out is set to 0 and the baud counter is set to 0.
REQ-017 The baud counter SHALL count 0..CLKS_PER_BIT-1 while the FSM is not in IDLE.
  - baud_tick=1 when count=CLKS_PER_BIT-1.
  - The counter wraps to 0 on the following edge.
  - The counter SHALL hold at 0 in IDLE.
REQ-018 Each bit SHALL be driven on tx_out for exactly CLKS_PER_BIT cycles; the state and bit advance only on edges where baud_tick=1.
REQ-019 START -> DATA on baud_tick; tx_out is set to data bit 0.
REQ-020 DATA SHALL transmit LSB first, using a bit index 0..FRAME_WIDTH-1.
  - On baud_tick with index<FRAME_WIDTH-1: the index increments and the next bit is driven.
  - On baud_tick at the last index: the FSM moves to PARITY if PARITY_EN=1, otherwise to STOP.
REQ-021 The parity bit SHALL be the XOR of all latched data bits, inverted when PARITY_ODD=1; PARITY -> STOP on baud_tick.
REQ-022 STOP SHALL drive tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - tx_done is asserted on the final baud_tick.
  - The FSM moves to IDLE on that edge.
REQ-023 Frame duration, from the first tx_out=0 cycle to IDLE, SHALL be (1+FRAME_WIDTH+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-024 Back-to-back frames with tx_valid held high SHALL be separated by exactly one idle cycle (tx_out=1), the cycle in which the next frame is accepted.
REQ-025 tx_valid and tx_data changes while tx_busy=1 SHALL be ignored; the frame in flight is unaffected.
REQ-026 tx_out SHALL be glitch-free, i.e. driven directly from a flop.

Reset
REQ-027 While rst=1, on each edge the block SHALL set:
  - FSM=IDLE;
  - tx_out=1;
  - baud counter and bit index to 0;
  - shift register to 0.
REQ-028 While rst=1, the outputs SHALL be tx_ready=0, tx_busy=0, baud_tick=0 and tx_done=0.
REQ-029 rst asserted mid-frame SHALL abort the frame:
  - tx_out=1 from the next cycle;
  - no tx_done pulse;
  - the data is discarded;
  - tx_ready=1 in the first cycle after rst deasserts.

Verification (CLKS_PER_BIT=4, FRAME_WIDTH=8 unless stated)
REQ-030 Send 0xA5 with no parity and 1 stop bit -> tx_out bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done in cycle 40 after acceptance; 10 baud_tick pulses.
REQ-031 PARITY_EN=1 -> 0x07 gives parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; frame length is 44 cycles.
REQ-032 0x00 then 0xFF with tx_valid held high -> exactly one tx_out=1 idle cycle between the first stop bit and the second start bit; each frame is accepted once.
REQ-033 rst for 1 cycle during data bit 3 -> tx_out=1 next cycle, no tx_done, tx_ready=1 after rst deasserts, and the next frame is sent correctly.
REQ-034 tx_data changed to 0x3C with tx_valid=1 mid-frame of 0xA5 -> the 0xA5 waveform is unchanged; 0x3C is accepted only in IDLE.
REQ-035 STOP_BITS=2 -> the stop level holds 8 cycles and tx_done lands in cycle 44.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// tx_out comes straight from a flop; the baud counter runs only while a frame is in flight.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_WIDTH  = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FRAME_WIDTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_out,
    output logic                   tx_busy,
    output logic                   baud_tick,
    output logic                   tx_done
);

    // state  | meaning
    // IDLE   | line high, waiting for tx_valid
    // START  | driving the start bit (0)
    // DATA   | shifting data bits out, LSB first
    // PARITY | driving the parity bit
    // STOP   | driving stop bit(s) (1)
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD       = 1'(PARITY_ODD);

    logic [2:0]             state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic                   stop_cnt;
    logic [FRAME_WIDTH-1:0] shreg;
    logic                   parity_bit;
    logic                   in_idle;

    // Status outputs are forced low during reset, even before state has returned to IDLE.
    always_comb begin
        in_idle   = (state == IDLE);
        tx_ready  = in_idle && !rst;
        tx_busy   = !in_idle && !rst;
        baud_tick = !in_idle && !rst && (baud_cnt == CNT_LAST);
        tx_done   = baud_tick && (state == STOP) && (stop_cnt == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tx_out     <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
            shreg      <= '0;
            parity_bit <= 1'b0;
        end else if (in_idle) begin
            baud_cnt <= '0;
            if (tx_valid) begin
                shreg      <= tx_data;
                parity_bit <= (^tx_data) ^ ODD;
                bit_idx    <= '0;
                stop_cnt   <= 1'b0;
                tx_out     <= 1'b0;
                state      <= START;
            end
        end else begin
            baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
            if (baud_tick) begin
                case (state)
                    START: begin
                        tx_out <= shreg[0];
                        shreg  <= shreg >> 1;
                        state  <= DATA;
                    end
                    DATA: begin
                        if (bit_idx == IDX_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx_out <= parity_bit;
                                state  <= PARITY;
                            end else begin
                                tx_out <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                    PARITY: begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                    end
                    STOP: begin
                        if (stop_cnt == STOP_LAST) state <= IDLE;
                        else stop_cnt <= stop_cnt + 1'b1;
                    end
                    default: begin
                        tx_out <= 1'b1;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at 4 clocks per bit: plain, even/odd parity and two-stop-bit builds.
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       valid   [4];
    logic       rdy     [4];
    logic       out_tx  [4];
    logic       busy    [4];
    logic       tick    [4];
    logic       done    [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[0]), .tx_ready(rdy[0]),
        .tx_out(out_tx[0]), .tx_busy(busy[0]), .baud_tick(tick[0]), .tx_done(done[0]));

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[1]), .tx_ready(rdy[1]),
        .tx_out(out_tx[1]), .tx_busy(busy[1]), .baud_tick(tick[1]), .tx_done(done[1]));

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[2]), .tx_ready(rdy[2]),
        .tx_out(out_tx[2]), .tx_busy(busy[2]), .baud_tick(tick[2]), .tx_done(done[2]));

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_s2 (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid[3]), .tx_ready(rdy[3]),
        .tx_out(out_tx[3]), .tx_busy(busy[3]), .baud_tick(tick[3]), .tx_done(done[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // bits: expected line level per bit period, index 0 = start bit.
    task automatic run_frame(input int inst, input logic [7:0] d, input logic [11:0] bits,
                             input int nbits, input bit hold, input bit mid_change);
        int ticks = 0;
        @(negedge clk);
        tx_data     = d;
        valid[inst] = 1'b1;
        check("accept_ready", rdy[inst], 1'b1);
        check("accept_idle_line", out_tx[inst], 1'b1);
        for (int c = 1; c <= nbits * 4; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) valid[inst] = 1'b0;
            check("line", out_tx[inst], bits[(c - 1) / 4]);
            check("done", done[inst], (c == nbits * 4));
            if (c == 1 || c == nbits * 4) check("busy", busy[inst], 1'b1);
            if (tick[inst]) ticks++;
            if (mid_change && c == 10) begin
                tx_data     = 8'h3C;
                valid[inst] = 1'b1;
            end
        end
        check("tick_count", ticks, nbits);
    endtask

    task automatic idle_watch(input int inst, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_line", out_tx[inst], 1'b1);
            check("idle_busy", busy[inst], 1'b0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        tx_data = 8'h00;
        for (int i = 0; i < 4; i++) valid[i] = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_line", out_tx[0], 1'b1);
        check("rst_ready", rdy[0], 1'b0);
        check("rst_busy", busy[0], 1'b0);
        check("rst_tick", tick[0], 1'b0);
        check("rst_done", done[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", rdy[0], 1'b1);

        // 0xA5, no parity, one stop bit
        run_frame(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b0);

        // back-to-back 0x00 then 0xFF with tx_valid held
        run_frame(0, 8'h00, {2'b00, 1'b1, 8'h00, 1'b0}, 10, 1'b1, 1'b0);
        run_frame(0, 8'hFF, {2'b00, 1'b1, 8'hFF, 1'b0}, 10, 1'b0, 1'b0);
        idle_watch(0, 6);

        // tx_data/tx_valid disturbed mid-frame; 0x3C must follow only from IDLE
        run_frame(0, 8'hA5, {2'b00, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, 1'b1);
        run_frame(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 1'b0);
        idle_watch(0, 3);

        // one-cycle reset during data bit 3 of 0xF0
        @(negedge clk);
        tx_data  = 8'hF0;
        valid[0] = 1'b1;
        check("abort_accept", rdy[0], 1'b1);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) valid[0] = 1'b0;
            check("abort_line", out_tx[0], (c <= 4) ? 1'b0 : (c <= 16 ? 1'b0 : 1'b0));
            check("abort_done", done[0], 1'b0);
        end
        rst = 1'b1;
        #1;
        check("abort_rst_busy", busy[0], 1'b0);
        check("abort_rst_ready", rdy[0], 1'b0);
        check("abort_rst_done", done[0], 1'b0);
        @(negedge clk);
        check("abort_line_high", out_tx[0], 1'b1);
        check("abort_done_low", done[0], 1'b0);
        check("abort_busy_low", busy[0], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready_after", rdy[0], 1'b1);
        check("abort_line_after", out_tx[0], 1'b1);
        run_frame(0, 8'h3C, {2'b00, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, 1'b0);

        // parity builds: 0x07 has three ones -> even parity 1, odd parity 0
        run_frame(1, 8'h07, {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b0, 1'b0);
        run_frame(2, 8'h07, {1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b0, 1'b0);

        // two stop bits: stop level 8 cycles, tx_done in cycle 44
        run_frame(3, 8'hA5, {1'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, 1'b0, 1'b0);
        idle_watch(3, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
